// File: rtl/timer_sched.sv
// Round-robin scheduler sharing one down-counting timeout timer among NREQ requesters.
// Optional macro TIMER_SCHED_TICK_EN adds tick_i, which gates the countdown in RUN.
module timer_sched #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*CNT_W-1:0] load_i,
`ifdef TIMER_SCHED_TICK_EN
    input  logic                  tick_i,
`endif
    output logic [NREQ-1:0]       grant_o,
    output logic [NREQ-1:0]       timeout_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      count_o
);

    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                      state, state_nxt;
    logic [PTR_W-1:0]            last, last_nxt;
    logic [NREQ-1:0]             grant_nxt;
    logic [CNT_W-1:0]            count_nxt;
    logic [NREQ-1:0][CNT_W-1:0]  slot;
    logic                        tick;
    logic                        found;
    logic [PTR_W-1:0]            win;
    logic                        owner_req;
    int                          idx;

    for (genvar k = 0; k < NREQ; k++) begin : g_slot
        assign slot[k] = load_i[k*CNT_W +: CNT_W];
    end

`ifdef TIMER_SCHED_TICK_EN
    assign tick = tick_i;
`else
    assign tick = 1'b1;
`endif

    // The RR pointer always names the current owner while busy.
    assign owner_req = req_i[last];

    // Scan from last+1 upward with wrap; the first set request wins.
    always_comb begin
        found = 1'b0;
        win   = last;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        grant_nxt = grant_o;
        count_nxt = count_o;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt      = '0;
                    grant_nxt[win] = 1'b1;
                    last_nxt       = win;
                    state_nxt      = LOAD;
                end
            end
            LOAD: begin
                // Withdrawal wins over loading, so count_o keeps its old value.
                if (!owner_req) begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = slot[last];
                    state_nxt = (slot[last] == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end else if (tick) begin
                    count_nxt = count_o - 1'b1;
                    if (count_o == CNT_W'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            last    <= PTR_W'(NREQ - 1);
            grant_o <= '0;
            count_o <= '0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            grant_o <= grant_nxt;
            count_o <= count_nxt;
        end
    end

    assign timeout_o = (state == DONE) ? grant_o : '0;
    assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched (NREQ=4, CNT_W=16); define TIMER_SCHED_TICK_EN to add the tick scenario.
module tb_timer_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req_i;
    logic [63:0] load_i;
`ifdef TIMER_SCHED_TICK_EN
    logic        tick_i;
`endif
    logic [3:0]  grant_o;
    logic [3:0]  timeout_o;
    logic        busy_o;
    logic [15:0] count_o;

    int errors = 0;
    int checks = 0;

    timer_sched #(.NREQ(4), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .load_i    (load_i),
`ifdef TIMER_SCHED_TICK_EN
        .tick_i    (tick_i),
`endif
        .grant_o   (grant_o),
        .timeout_o (timeout_o),
        .busy_o    (busy_o),
        .count_o   (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1ns after the active edge; inputs change at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_i = '0;
        load_i = '0;
        #3;
        checks++;
        if ({grant_o, timeout_o, busy_o, count_o} !== 25'd0) begin
            errors++;
            $display("FAIL reset_in got g=%b t=%b b=%b c=%0d exp all zero", grant_o, timeout_o, busy_o, count_o);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({grant_o, timeout_o, busy_o, count_o} !== 25'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d] got g=%b t=%b b=%b c=%0d exp all zero", i, grant_o, timeout_o, busy_o, count_o);
            end
        end
    endtask

    task automatic test_single();
        logic [15:0] exp_c [3];
        exp_c = '{16'd3, 16'd2, 16'd1};
        req_i = 4'b0001;
        load_i[15:0] = 16'd3;
        step();  // t+1: LOAD
        checks++;
        if (grant_o !== 4'b0001 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got g=%b b=%b exp g=0001 b=1", grant_o, busy_o);
        end
        for (int i = 0; i < 3; i++) begin  // t+2..t+4: RUN
            step();
            checks++;
            if (count_o !== exp_c[i] || timeout_o !== 4'b0000) begin
                errors++;
                $display("FAIL single_run[%0d] got c=%0d t=%b exp c=%0d t=0000", i, count_o, timeout_o, exp_c[i]);
            end
        end
        step();  // t+5: DONE
        checks++;
        if (timeout_o !== 4'b0001 || count_o !== 16'd0) begin
            errors++;
            $display("FAIL single_done got t=%b c=%0d exp t=0001 c=0", timeout_o, count_o);
        end
        req_i = 4'b0000;
        step();  // t+6: IDLE
        checks++;
        if (grant_o !== 4'b0000 || timeout_o !== 4'b0000 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got g=%b t=%b b=%b exp 0000 0000 0", grant_o, timeout_o, busy_o);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step();
        load_i = '0;
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();  // LOAD
            checks++;
            if (grant_o !== exp_g[k] || timeout_o !== 4'b0000) begin
                errors++;
                $display("FAIL rr_grant[%0d] got g=%b t=%b exp g=%b t=0000", k, grant_o, timeout_o, exp_g[k]);
            end
            step();  // DONE
            checks++;
            if (timeout_o !== exp_g[k]) begin
                errors++;
                $display("FAIL rr_timeout[%0d] got %b exp %b", k, timeout_o, exp_g[k]);
            end
            step();  // IDLE
            checks++;
            if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle[%0d] got g=%b b=%b exp 0000 0", k, grant_o, busy_o);
            end
            if (k == 4) req_i = 4'b0000;
        end
    endtask

    task automatic test_abort();
        req_i = 4'b0100;
        load_i[47:32] = 16'd10;
        step();  // LOAD
        checks++;
        if (grant_o !== 4'b0100) begin
            errors++;
            $display("FAIL abort_grant got %b exp 0100", grant_o);
        end
        for (int i = 0; i < 5; i++) step();  // counts 10,9,8,7,6
        checks++;
        if (count_o !== 16'd6) begin
            errors++;
            $display("FAIL abort_count got %0d exp 6", count_o);
        end
        req_i = 4'b1000;
        load_i[63:48] = 16'd5;
        step();
        checks++;
        if (grant_o !== 4'b0000 || busy_o !== 1'b0 || timeout_o !== 4'b0000 || count_o !== 16'd6) begin
            errors++;
            $display("FAIL abort_idle got g=%b b=%b t=%b c=%0d exp 0000 0 0000 6", grant_o, busy_o, timeout_o, count_o);
        end
        step();
        checks++;
        if (grant_o !== 4'b1000) begin
            errors++;
            $display("FAIL abort_next_grant got %b exp 1000", grant_o);
        end
        req_i = 4'b0000;  // withdraw during LOAD: no load happens
        step();
        checks++;
        if (grant_o !== 4'b0000 || busy_o !== 1'b0 || count_o !== 16'd6) begin
            errors++;
            $display("FAIL abort_load got g=%b b=%b c=%0d exp 0000 0 6", grant_o, busy_o, count_o);
        end
    endtask

    task automatic test_reset_mid_run();
        req_i = 4'b0001;
        load_i[15:0] = 16'd8;
        for (int i = 0; i < 5; i++) step();  // LOAD, then counts 8,7,6,5
        checks++;
        if (count_o !== 16'd5 || grant_o !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_pre got c=%0d g=%b exp c=5 g=0001", count_o, grant_o);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({grant_o, timeout_o, busy_o, count_o} !== 25'd0) begin
            errors++;
            $display("FAIL midrst_zero got g=%b t=%b b=%b c=%0d exp all zero", grant_o, timeout_o, busy_o, count_o);
        end
        step();
        reset = 1'b1;
        req_i = 4'b0011;
        step();
        checks++;
        if (grant_o !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_ptr got %b exp 0001", grant_o);
        end
        req_i = 4'b0000;
        step();
        checks++;
        if (busy_o !== 1'b0 || timeout_o !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_idle got b=%b t=%b exp 0 0000", busy_o, timeout_o);
        end
    endtask

`ifdef TIMER_SCHED_TICK_EN
    task automatic test_tick();
        logic [15:0] exp_c [7];
        logic [3:0]  exp_t [7];
        exp_c = '{16'd2, 16'd2, 16'd2, 16'd1, 16'd1, 16'd1, 16'd0};
        exp_t = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        tick_i = 1'b0;
        req_i = 4'b0001;
        load_i[15:0] = 16'd2;
        step();  // LOAD
        step();  // RUN, count 2
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (count_o !== exp_c[i] || timeout_o !== exp_t[i]) begin
                errors++;
                $display("FAIL tick[%0d] got c=%0d t=%b exp c=%0d t=%b", i, count_o, timeout_o, exp_c[i], exp_t[i]);
            end
            tick_i = (i % 3 == 2);
            if (i == 6) req_i = 4'b0000;
            step();
        end
        tick_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin
            errors++;
            $display("FAIL tick_idle got b=%b g=%b exp 0 0000", busy_o, grant_o);
        end
    endtask
`endif

    initial begin
`ifdef TIMER_SCHED_TICK_EN
        tick_i = 1'b1;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_reset_mid_run();
`ifdef TIMER_SCHED_TICK_EN
        test_tick();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
